// File: rtl/dc_bp_if.sv
// dc_bp_if: CSR master bus between the back-pressure poller and the DC FIFO CSR slaves
interface dc_bp_if #(
  parameter int NUM_CH  = 4,
  parameter int LEVEL_W = 32
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic [CH_W-1:0]    csr_chan;
  logic               csr_address;
  logic               csr_read;
  logic               csr_write;
  logic [LEVEL_W-1:0] csr_writedata;
  logic               csr_waitrequest;
  logic [LEVEL_W-1:0] csr_readdata;
  logic               csr_readdatavalid;
  modport master (
    output csr_chan, csr_address, csr_read, csr_write, csr_writedata,
    input  csr_waitrequest, csr_readdata, csr_readdatavalid
  );
  modport slave (
    input  csr_chan, csr_address, csr_read, csr_write, csr_writedata,
    output csr_waitrequest, csr_readdata, csr_readdatavalid
  );
endinterface

// File: rtl/dc_back_pressure_mc.sv
// dc_back_pressure_mc: round-robin fill-level poller driving per-channel almost_full with hysteresis; DC_BP_PEAK_EN adds per-channel peak tracking
module dc_back_pressure_mc #(
  parameter int NUM_CH   = 4,
  parameter int LEVEL_W  = 32,
  parameter int HI_LEVEL = 490,
  parameter int LO_LEVEL = 450,
  parameter int TIMEOUT  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  dc_bp_if.master           csr,
  output logic [NUM_CH-1:0] almost_full,
  output logic              any_almost_full,
  output logic [NUM_CH-1:0] timeout_err,
  input  logic              clr_err
`ifdef DC_BP_PEAK_EN
  ,
  input  logic                      peak_clr,
  output logic [NUM_CH*LEVEL_W-1:0] peak_level
`endif
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int TM_W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, UPD} state_t;
  state_t             state_q, state_d;
  logic [CH_W-1:0]    chan_q, chan_d, chan_nxt;
  logic               read_q, read_d, any_q, any_d;
  logic [TM_W-1:0]    timer_q, timer_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [NUM_CH-1:0]  af_q, af_d, err_q, err_d;
  assign chan_nxt = chan_q == CH_W'(NUM_CH - 1) ? '0 : chan_q + 1'b1;
  // next-state: poll one channel per pass; a silent slave times out and fails safe to almost_full
  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    timer_d = timer_q;
    level_d = level_q;
    af_d    = af_q;
    err_d   = clr_err ? '0 : err_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: if (!csr.csr_waitrequest) begin
        state_d = WAIT;
        timer_d = '0;
      end
      WAIT: if (csr.csr_readdatavalid) begin
        level_d = csr.csr_readdata;
        state_d = UPD;
      end else if (timer_q == TM_W'(TIMEOUT - 1)) begin
        err_d[chan_q] = 1'b1;
        af_d[chan_q]  = 1'b1;
        chan_d        = chan_nxt;
        state_d       = REQ;
      end else begin
        timer_d = timer_q + 1'b1;
      end
      default: begin
        af_d[chan_q] = level_q >= LEVEL_W'(HI_LEVEL) ? 1'b1 :
                       level_q <  LEVEL_W'(LO_LEVEL) ? 1'b0 : af_q[chan_q];
        chan_d       = chan_nxt;
        state_d      = REQ;
      end
    endcase
    read_d = state_d == REQ;
    any_d  = |af_q;
  end
  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      chan_q  <= '0;
      read_q  <= 1'b0;
      timer_q <= '0;
      level_q <= '0;
      af_q    <= '0;
      any_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      read_q  <= read_d;
      timer_q <= timer_d;
      level_q <= level_d;
      af_q    <= af_d;
      any_q   <= any_d;
      err_q   <= err_d;
    end
  assign csr.csr_chan      = chan_q;
  assign csr.csr_address   = 1'b0;
  assign csr.csr_read      = read_q;
  assign csr.csr_write     = 1'b0;
  assign csr.csr_writedata = '0;
  assign almost_full       = af_q;
  assign any_almost_full   = any_q;
  assign timeout_err       = err_q;
`ifdef DC_BP_PEAK_EN
  logic [NUM_CH-1:0][LEVEL_W-1:0] peak_q, peak_d;
  // peak tracking: clear zeroes all, but a coincident update loads the fresh level
  always_comb begin
    peak_d = peak_clr ? '0 : peak_q;
    if (state_q == UPD && (peak_clr || level_q > peak_q[chan_q])) peak_d[chan_q] = level_q;
  end
  // peak registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) peak_q <= '0;
    else peak_q <= peak_d;
  assign peak_level = peak_q;
`endif
endmodule

// File: tb/tb_dc_back_pressure_mc.sv
// tb_dc_back_pressure_mc: random and directed checks of the poller against a transaction-level model
module tb_dc_back_pressure_mc;
  logic clk = 1'b0, rst_n = 1'b0, clr_err = 1'b0;
  logic [3:0] almost_full, timeout_err;
  logic any_almost_full;
  dc_bp_if #(.NUM_CH(4), .LEVEL_W(32)) bus ();
`ifdef DC_BP_PEAK_EN
  logic peak_clr = 1'b0, force_pclr = 1'b0;
  logic [127:0] peak_level;
  logic [31:0] m_peak [4];
`endif
  dc_back_pressure_mc #(.NUM_CH(4), .LEVEL_W(32), .HI_LEVEL(490), .LO_LEVEL(450), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .csr(bus), .almost_full(almost_full),
    .any_almost_full(any_almost_full), .timeout_err(timeout_err), .clr_err(clr_err)
`ifdef DC_BP_PEAK_EN
    , .peak_clr(peak_clr), .peak_level(peak_level)
`endif
  );
  always #5 clk = ~clk;
  int pass_cnt = 0, total_cnt = 0;
  logic [3:0] m_af, m_err;
  logic m_any, m_read;
  logic [1:0] m_chan;
  int phase, w, dly, never_ch;
  bit never, rnd, force_clr, force_stray, force_wr;
  logic [31:0] lvl, m_lvl;
  logic [31:0] lv_tab [4];
  logic [31:0] pick_tab [8];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // one clock: compare outputs with the model, drive the slave, advance the model across the edge
  task automatic step();
    logic [3:0] af_n, err_n;
    logic read_n, any_n;
    logic [1:0] chan_n;
    int ph_n;
    bit wr, rv;
`ifdef DC_BP_PEAK_EN
    logic [31:0] pk_n [4];
`endif
    chk("csr_read", 32'(bus.csr_read), 32'(m_read));
    chk("csr_chan", 32'(bus.csr_chan), 32'(m_chan));
    chk("almost_full", 32'(almost_full), 32'(m_af));
    chk("any_almost_full", 32'(any_almost_full), 32'(m_any));
    chk("timeout_err", 32'(timeout_err), 32'(m_err));
    chk("csr_write", 32'(bus.csr_write), 0);
`ifdef DC_BP_PEAK_EN
    for (int i = 0; i < 4; i++) chk("peak_level", peak_level[i*32 +: 32], m_peak[i]);
    peak_clr = force_pclr || (rnd && $urandom_range(49) == 0);
    for (int i = 0; i < 4; i++) pk_n[i] = peak_clr ? 32'd0 : m_peak[i];
`endif
    wr = force_wr || (rnd && $urandom_range(2) == 0);
    clr_err = force_clr || (rnd && $urandom_range(39) == 0);
    rv = force_stray || (rnd && $urandom_range(4) == 0);
    bus.csr_readdata = force_stray ? 32'd600 : $urandom;
    af_n = m_af;
    err_n = clr_err ? 4'd0 : m_err;
    any_n = |m_af;
    read_n = m_read;
    chan_n = m_chan;
    ph_n = phase;
    if (phase == 0) begin
      ph_n = 1;
      read_n = 1'b1;
    end else if (phase == 1) begin
      if (!wr) begin
        ph_n = 2;
        read_n = 1'b0;
        w = 0;
        lvl = rnd ? pick_tab[$urandom_range(7)] : lv_tab[m_chan];
        if (rnd && $urandom_range(9) == 0) lvl = $urandom;
        never = rnd ? ($urandom_range(29) == 0) : (int'(m_chan) == never_ch);
        dly = rnd ? ($urandom_range(9) == 0 ? 63 : int'($urandom_range(3))) : 0;
      end
    end else if (phase == 2) begin
      rv = !never && w == dly;
      if (rv) begin
        bus.csr_readdata = lvl;
        m_lvl = lvl;
        ph_n = 3;
      end else if (w == 63) begin
        err_n[m_chan] = 1'b1;
        af_n[m_chan] = 1'b1;
        chan_n = m_chan + 2'd1;
        read_n = 1'b1;
        ph_n = 1;
      end else w++;
    end else begin
      if (m_lvl >= 490) af_n[m_chan] = 1'b1;
      else if (m_lvl < 450) af_n[m_chan] = 1'b0;
`ifdef DC_BP_PEAK_EN
      pk_n[m_chan] = (peak_clr || m_lvl > m_peak[m_chan]) ? m_lvl : m_peak[m_chan];
`endif
      chan_n = m_chan + 2'd1;
      read_n = 1'b1;
      ph_n = 1;
    end
    bus.csr_waitrequest = wr;
    bus.csr_readdatavalid = rv;
    @(posedge clk);
    m_af = af_n;
    m_err = err_n;
    m_any = any_n;
    m_read = read_n;
    m_chan = chan_n;
    phase = ph_n;
`ifdef DC_BP_PEAK_EN
    for (int i = 0; i < 4; i++) m_peak[i] = pk_n[i];
`endif
    @(negedge clk);
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // asynchronous reset at a falling edge, released at the next one
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst almost_full", 32'(almost_full), 0);
    chk("rst any_almost_full", 32'(any_almost_full), 0);
    chk("rst timeout_err", 32'(timeout_err), 0);
    chk("rst csr_read", 32'(bus.csr_read), 0);
    chk("rst csr_chan", 32'(bus.csr_chan), 0);
    m_af = 0; m_err = 0; m_any = 0; m_read = 0; m_chan = 0; phase = 0; w = 0;
`ifdef DC_BP_PEAK_EN
    for (int i = 0; i < 4; i++) m_peak[i] = 0;
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    pick_tab = '{32'd0, 32'd449, 32'd450, 32'd470, 32'd489, 32'd490, 32'd491, 32'd600};
    bus.csr_waitrequest = 1'b0;
    bus.csr_readdata = 0;
    bus.csr_readdatavalid = 1'b0;
    rnd = 0; never_ch = 15; force_clr = 0; force_stray = 0; force_wr = 0;
    @(negedge clk);
    do_reset();
    // zero-wait sweep
    lv_tab = '{32'd0, 32'd490, 32'd489, 32'd600};
    steps(16);
    chk("sweep almost_full", 32'(almost_full), 32'b1010);
    chk("sweep any", 32'(any_almost_full), 1);
    // hysteresis on channel 0
    lv_tab[0] = 500; steps(15);
    chk("hyst 500", 32'(almost_full[0]), 1);
    lv_tab[0] = 470; steps(15);
    chk("hyst 470", 32'(almost_full[0]), 1);
    lv_tab[0] = 450; steps(15);
    chk("hyst 450", 32'(almost_full[0]), 1);
    lv_tab[0] = 449; steps(15);
    chk("hyst 449", 32'(almost_full[0]), 0);
    // waitrequest held for 5 cycles
    for (int i = 0; i < 10 && phase != 1; i++) step();
    force_wr = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall read", 32'(bus.csr_read), 1);
    end
    force_wr = 0;
    steps(6);
    // channel 2 never answers
    do_reset();
    lv_tab = '{32'd0, 32'd0, 32'd0, 32'd0};
    never_ch = 2;
    steps(71);
    chk("pre-timeout err", 32'(timeout_err), 0);
    step();
    chk("timeout err", 32'(timeout_err), 32'b0100);
    chk("timeout af", 32'(almost_full), 32'b0100);
    chk("timeout next chan", 32'(bus.csr_chan), 3);
    never_ch = 15;
    force_clr = 1; step(); force_clr = 0;
    chk("clr_err", 32'(timeout_err), 0);
    chk("af held after clr", 32'(almost_full[2]), 1);
    steps(15);
    chk("af cleared by read", 32'(almost_full), 0);
    // randomized traffic
    rnd = 1;
    steps(1500);
    // reset during a wait, stale data afterwards
    for (int i = 0; i < 400 && phase != 2; i++) step();
    chk("reached wait", 32'(phase), 2);
    rnd = 0;
    do_reset();
    force_stray = 1;
    step();
    chk("restart read", 32'(bus.csr_read), 1);
    chk("restart chan", 32'(bus.csr_chan), 0);
    step();
    force_stray = 0;
    steps(20);
    chk("stale ignored", 32'(almost_full), 0);
`ifdef DC_BP_PEAK_EN
    lv_tab[1] = 100; steps(15);
    lv_tab[1] = 300; steps(15);
    lv_tab[1] = 200; steps(15);
    chk("peak 300", peak_level[32 +: 32], 300);
    for (int i = 0; i < 20 && !(phase == 1 && m_chan == 3); i++) step();
    force_pclr = 1; step(); force_pclr = 0;
    chk("peak cleared", peak_level[32 +: 32], 0);
    steps(15);
    chk("peak 200", peak_level[32 +: 32], 200);
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
